// File: rtl/jtframe_upload_pkg.sv
// Shared types and constants for the HPS upload reader.
// Holds the FSM encoding, the fill byte and the byte-lane selector.
package jtframe_upload_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } state_t;

    localparam logic [7:0] FILL = 8'hFF;

    function automatic logic [7:0] byte_sel(input logic [15:0] w,
                                            input logic        hi);
        return hi ? w[15:8] : w[7:0];
    endfunction

endpackage

// File: rtl/jtframe_upload_cache.sv
// One-word read cache: tag, valid bit, data word and byte-lane select.
// Invalidation takes priority over a load in the same cycle.
module jtframe_upload_cache
    import jtframe_upload_pkg::*;
#(
    parameter int AW = 22
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inv,
    input  logic          load,
    input  logic [AW-2:0] load_tag,
    input  logic [15:0]   load_data,
    input  logic [AW-2:0] look_tag,
    input  logic          sel_hi,
    output logic          hit,
    output logic [7:0]    dout
);

    logic [AW-2:0] tag;
    logic [15:0]   data;
    logic          valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag   <= '0;
            data  <= '0;
            valid <= 1'b0;
        end else if (inv) begin
            valid <= 1'b0;
        end else if (load) begin
            tag   <= load_tag;
            data  <= load_data;
            valid <= 1'b1;
        end
    end

    assign hit  = valid && (tag == look_tag);
    assign dout = byte_sel(data, sel_hi);

endmodule

// File: rtl/jtframe_upload.sv
// Byte-wide HPS upload port reading a 16-bit memory through a one-word
// cache, with a request watchdog and session abort handling.
module jtframe_upload
    import jtframe_upload_pkg::*;
#(
    parameter int          AW         = 22,
    parameter int unsigned UPLOAD_LEN = 22'h10000,
    parameter int          TOUT       = 255
) (
    input  logic          clk_sys,
    input  logic          rst,
    input  logic          ioctl_upload,
    input  logic          ioctl_rd,
    input  logic [AW-1:0] ioctl_addr,
    output logic [7:0]    ioctl_din,
    output logic          upload_rdy,
    output logic [AW-2:0] mem_addr,
    output logic          mem_req,
    input  logic          mem_ack,
    input  logic [15:0]   mem_dout,
    input  logic          mem_rdy,
    output logic          overrun,
    output logic          tout_err
);

    localparam int          WW  = $clog2(TOUT + 1);
    localparam logic [AW:0] LEN = (AW + 1)'(UPLOAD_LEN);

    state_t        state;
    logic [WW-1:0] wdog;
    logic          sel_hi;
    logic          fill;
    logic          sent;
    logic          upload_l;
    logic          in_range;
    logic          hit;
    logic [7:0]    cache_byte;
    logic          expire;
    logic          tout_evt;
    logic          rise;
    logic          cache_inv;
    logic          cache_load;

    assign in_range = {1'b0, ioctl_addr} < LEN;
    assign rise     = ioctl_upload && !upload_l;
    assign expire   = wdog == WW'(TOUT - 1);
    assign tout_evt = ioctl_upload && expire &&
                      ((state == REQ  && !mem_ack) ||
                       (state == WAIT && !mem_rdy));

    // Outside a session the cache is kept empty, so an abort and a new
    // session both start from an invalid cache.
    assign cache_inv  = !ioctl_upload || rise || tout_evt;
    assign cache_load = ioctl_upload && state == WAIT && mem_rdy;

    jtframe_upload_cache #(.AW(AW)) u_cache (
        .clk       (clk_sys),
        .rst       (rst),
        .inv       (cache_inv),
        .load      (cache_load),
        .load_tag  (mem_addr),
        .load_data (mem_dout),
        .look_tag  (ioctl_addr[AW-1:1]),
        .sel_hi    (sel_hi),
        .hit       (hit),
        .dout      (cache_byte)
    );

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wdog       <= '0;
            sel_hi     <= 1'b0;
            fill       <= 1'b0;
            sent       <= 1'b0;
            upload_l   <= 1'b0;
            ioctl_din  <= '0;
            upload_rdy <= 1'b0;
            mem_addr   <= '0;
            mem_req    <= 1'b0;
            overrun    <= 1'b0;
            tout_err   <= 1'b0;
        end else begin
            upload_l   <= ioctl_upload;
            upload_rdy <= 1'b0;
            if (rise) begin
                overrun  <= 1'b0;
                tout_err <= 1'b0;
            end
            if (!ioctl_upload) begin
                state   <= IDLE;
                mem_req <= 1'b0;
                sent    <= 1'b0;
                wdog    <= '0;
            end else begin
                if (ioctl_rd && state != IDLE) overrun <= 1'b1;
                unique case (state)
                    IDLE: if (ioctl_rd) begin
                        sel_hi <= ioctl_addr[0];
                        wdog   <= '0;
                        fill   <= !in_range;
                        if (!in_range || hit) begin
                            state <= RESP;
                        end else begin
                            mem_req  <= 1'b1;
                            mem_addr <= ioctl_addr[AW-1:1];
                            state    <= REQ;
                        end
                    end
                    REQ: if (mem_ack) begin
                        mem_req <= 1'b0;
                        wdog    <= '0;
                        state   <= WAIT;
                    end else if (tout_evt) begin
                        tout_err <= 1'b1;
                        mem_req  <= 1'b0;
                        fill     <= 1'b1;
                        wdog     <= '0;
                        state    <= RESP;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                    // Data wins over a watchdog expiry in the same cycle.
                    WAIT: if (mem_rdy) begin
                        ioctl_din  <= byte_sel(mem_dout, sel_hi);
                        upload_rdy <= 1'b1;
                        sent       <= 1'b1;
                        wdog       <= '0;
                        state      <= RESP;
                    end else if (tout_evt) begin
                        tout_err <= 1'b1;
                        fill     <= 1'b1;
                        wdog     <= '0;
                        state    <= RESP;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                    RESP: begin
                        if (!sent) begin
                            upload_rdy <= 1'b1;
                            ioctl_din  <= fill ? FILL : cache_byte;
                        end
                        sent  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jtframe_upload.sv
// Directed bench for jtframe_upload with a byte scoreboard.
// Expected bytes are queued at each read and popped on upload_rdy.
module tb_jtframe_upload;

    localparam int AW   = 22;
    localparam int TOUT = 255;
    localparam int LEN  = 22'h10000;

    logic          clk_sys = 1'b0;
    logic          rst = 1'b1;
    logic          ioctl_upload = 1'b0;
    logic          ioctl_rd = 1'b0;
    logic [AW-1:0] ioctl_addr = '0;
    logic [7:0]    ioctl_din;
    logic          upload_rdy;
    logic [AW-2:0] mem_addr;
    logic          mem_req;
    logic          mem_ack = 1'b0;
    logic [15:0]   mem_dout = '0;
    logic          mem_rdy = 1'b0;
    logic          overrun;
    logic          tout_err;

    int n_assert = 0;
    int n_fail = 0;
    int req_cnt = 0;
    int rdy_cnt = 0;
    logic [7:0] sb[$];

    jtframe_upload #(
        .AW(AW), .UPLOAD_LEN(LEN), .TOUT(TOUT)
    ) dut (
        .clk_sys      (clk_sys),
        .rst          (rst),
        .ioctl_upload (ioctl_upload),
        .ioctl_rd     (ioctl_rd),
        .ioctl_addr   (ioctl_addr),
        .ioctl_din    (ioctl_din),
        .upload_rdy   (upload_rdy),
        .mem_addr     (mem_addr),
        .mem_req      (mem_req),
        .mem_ack      (mem_ack),
        .mem_dout     (mem_dout),
        .mem_rdy      (mem_rdy),
        .overrun      (overrun),
        .tout_err     (tout_err)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk_sys)
        if (mem_req && mem_ack) req_cnt++;

    always @(negedge clk_sys) begin
        if (!rst && upload_rdy) begin
            rdy_cnt++;
            if (sb.size() == 0) check("rdy_extra", 1, 0);
            else check("din", {24'd0, ioctl_din}, {24'd0, sb.pop_front()});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic rd(input logic [AW-1:0] a, input bit push,
                      input logic [7:0] exp);
        tick(1);
        ioctl_rd   = 1'b1;
        ioctl_addr = a;
        if (push) sb.push_back(exp);
        tick(1);
        ioctl_rd = 1'b0;
    endtask

    task automatic wait_ack(input logic [AW-2:0] word);
        int k;
        k = 0;
        while (!mem_req && k < 20) begin
            tick(1);
            k++;
        end
        check("req_seen", {31'd0, mem_req}, 1);
        check("mem_addr", {11'd0, mem_addr}, {11'd0, word});
        mem_ack = 1'b1;
        tick(1);
        mem_ack = 1'b0;
    endtask

    task automatic give_rdy(input logic [15:0] d, input bit exp_rdy);
        tick(2);
        mem_dout = d;
        mem_rdy  = 1'b1;
        tick(1);
        mem_rdy = 1'b0;
        check("miss_lat", {31'd0, upload_rdy}, {31'd0, exp_rdy});
    endtask

    initial begin
        int r0, q0;
        #2;
        check("rst_rdy", {31'd0, upload_rdy}, 0);
        check("rst_req", {31'd0, mem_req}, 0);
        check("rst_din", {24'd0, ioctl_din}, 0);
        check("rst_addr", {11'd0, mem_addr}, 0);
        check("rst_flags", {30'd0, overrun, tout_err}, 0);
        tick(2);
        rst = 1'b0;
        ioctl_upload = 1'b1;
        tick(2);

        // miss then hit on the other byte of word 0
        rd(22'h0, 1, 8'hEF);
        wait_ack(21'h0);
        give_rdy(16'hBEEF, 1);
        rd(22'h1, 1, 8'hBE);
        check("hit_early", {31'd0, upload_rdy}, 0);
        tick(1);
        check("hit_lat", {31'd0, upload_rdy}, 1);
        check("hit_noreq", req_cnt, 1);

        // range boundary and wrap
        rd(22'(LEN), 1, 8'hFF);
        tick(1);
        check("oor_lat", {31'd0, upload_rdy}, 1);
        check("oor_noreq", {31'd0, mem_req}, 0);
        rd(22'h3FFFFF, 1, 8'hFF);
        tick(3);
        check("wrap_noreq", req_cnt, 1);
        rd(22'(LEN - 1), 1, 8'h5A);
        wait_ack(21'h7FFF);
        give_rdy(16'h5AA5, 1);

        // watchdog: data withheld for 300 cycles
        rd(22'h100, 1, 8'hFF);
        wait_ack(21'h80);
        tick(TOUT - 1);
        check("tout_early", {31'd0, tout_err}, 0);
        tick(1);
        check("tout_set", {31'd0, tout_err}, 1);
        check("tout_noreq", {31'd0, mem_req}, 0);
        tick(300 - TOUT);
        r0 = req_cnt;
        rd(22'hFFFE, 1, 8'hD2);
        wait_ack(21'h7FFF);
        give_rdy(16'hC3D2, 1);
        check("tout_refetch", req_cnt, r0 + 1);

        // second read while busy
        rd(22'h200, 1, 8'h77);
        wait_ack(21'h100);
        q0 = rdy_cnt;
        ioctl_rd   = 1'b1;
        ioctl_addr = 22'h201;
        tick(1);
        ioctl_rd = 1'b0;
        check("overrun", {31'd0, overrun}, 1);
        give_rdy(16'h6677, 1);
        tick(4);
        check("overrun_one", rdy_cnt, q0 + 1);

        // session abort in WAIT
        rd(22'h0, 1, 8'hB2);
        wait_ack(21'h0);
        give_rdy(16'hA1B2, 1);
        rd(22'h300, 0, 8'h00);
        wait_ack(21'h180);
        q0 = rdy_cnt;
        ioctl_upload = 1'b0;
        tick(1);
        give_rdy(16'h9999, 0);
        tick(2);
        check("abort_nordy", rdy_cnt, q0);
        check("abort_noreq", {31'd0, mem_req}, 0);
        ioctl_upload = 1'b1;
        tick(2);
        check("rise_clr", {30'd0, overrun, tout_err}, 0);
        r0 = req_cnt;
        rd(22'h1, 1, 8'hC4);
        wait_ack(21'h0);
        give_rdy(16'hC4D5, 1);
        check("abort_refetch", req_cnt, r0 + 1);

        // reset in WAIT
        rd(22'h400, 0, 8'h00);
        wait_ack(21'h200);
        ioctl_rd = 1'b1;
        tick(1);
        ioctl_rd = 1'b0;
        check("pre_rst_ovr", {31'd0, overrun}, 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_req", {31'd0, mem_req}, 0);
        check("arst_din", {24'd0, ioctl_din}, 0);
        check("arst_addr", {11'd0, mem_addr}, 0);
        check("arst_flags", {29'd0, overrun, tout_err, upload_rdy}, 0);
        tick(1);
        rst = 1'b0;
        q0 = rdy_cnt;
        give_rdy(16'h1111, 0);
        tick(3);
        check("rst_stale", rdy_cnt, q0);
        check("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
